// File: rtl/verify_load_sequencer.sv
// verify_load_sequencer: streams one Dilithium verify operation (rho, c, z, t1, mlen, m, h)
// from a synchronous-read operand buffer into the core and collects the accept/reject result.
//   clk, rst (async, active-low)
//   go, lvl_i, mlen_i               : run request, level and message length (sampled on go)
//   busy, done, reject, bad_lvl     : run status; reject and cycles hold until the next accepted go
//   cycles                          : clocks from the accepted go up to and including done
//   rd_en, rd_seg, rd_addr, rd_data : operand buffer port, data one cycle after rd_en
//   core_start/mode/lvl/valid/ready/data : core control and 64-bit input stream
//   res_valid, res_ready, res_data  : core result handshake, res_data == 1 means reject
module verify_load_sequencer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [2:0]       lvl_i,
   input  logic [15:0]      mlen_i,
   output logic             busy,
   output logic             done,
   output logic             reject,
   output logic             bad_lvl,
   output logic [CNT_W-1:0] cycles,
   output logic             rd_en,
   output logic [2:0]       rd_seg,
   output logic [9:0]       rd_addr,
   input  logic [63:0]      rd_data,
   output logic             core_start,
   output logic [1:0]       core_mode,
   output logic [2:0]       core_lvl,
   output logic             core_valid,
   input  logic             core_ready,
   output logic [63:0]      core_data,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [63:0]      res_data
);
   localparam logic [3:0] IDLE = 4'd0, START = 4'd1, RHO = 4'd2, H = 4'd8, RESULT = 4'd9;
   logic [3:0]  state;
   logic [1:0]  st_cnt;
   logic [2:0]  lvl;
   logic [15:0] mlen;
   logic [13:0] snd_cnt, iss_addr;
   logic [2:0]  iss_seg, snd_seg;
   logic        iss_act, inf_v, inf_m;
   logic [1:0]  q_cnt, wi;
   logic [63:0] q [3];
   logic [63:0] din;
   logic        legal, issue, push, pop, in_seg, snd_last, iss_last;
   // Segment index k follows stream order: 0 rho, 1 c, 2 z, 3 t1, 4 mlen, 5 m, 6 h.
   function automatic logic [13:0] seg_len(input logic [2:0] k, input logic [2:0] l, input logic [15:0] ml);
      logic [13:0] mw;
      mw = {1'b0, ml[15:3]} + {13'd0, |ml[2:0]};
      return k == 3'd2 ? (l == 3'd2 ? 14'd288 : l == 3'd3 ? 14'd400 : 14'd560) :
             k == 3'd3 ? (l == 3'd2 ? 14'd160 : l == 3'd3 ? 14'd240 : 14'd320) :
             k == 3'd4 ? 14'd1 :
             k == 3'd5 ? (ml == 16'd0 ? 14'd1 : mw) :
             k == 3'd6 ? (l == 3'd3 ? 14'd8 : 14'd11) : 14'd4;
   endfunction
   assign legal      = lvl_i == 3'd2 || lvl_i == 3'd3 || lvl_i == 3'd5;
   assign busy       = state != IDLE;
   assign done       = state == RESULT && res_valid;
   assign res_ready  = state == RESULT;
   assign core_start = state == START && st_cnt == 2'd2;
   assign core_mode  = 2'd1;
   assign core_lvl   = lvl;
   assign core_valid = q_cnt != 2'd0;
   assign core_data  = q[0];
   assign pop        = core_valid && core_ready;
   assign in_seg     = state >= RHO && state <= H;
   assign snd_seg    = 3'(state - RHO);
   assign snd_last   = snd_cnt == seg_len(snd_seg, lvl, mlen) - 14'd1;
   assign iss_last   = iss_addr == seg_len(iss_seg, lvl, mlen) - 14'd1;
   // q[0] is the output register, q[1..2] the skid FIFO; keep skid entries plus in-flight reads <= 1.
   assign issue      = iss_act && ({1'b0, q_cnt} + {2'b0, inf_v}) <= 3'd2;
   // The mlen word takes a read slot without touching the buffer so stream order stays intact.
   assign rd_en      = issue && iss_seg != 3'd4;
   assign rd_seg     = iss_seg > 3'd4 ? iss_seg - 3'd1 : iss_seg;
   assign rd_addr    = iss_addr[9:0];
   assign push       = inf_v;
   assign din        = inf_m ? {48'd0, mlen} : rd_data;
   assign wi         = q_cnt - 2'(pop);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         st_cnt   <= '0;
         lvl      <= '0;
         mlen     <= '0;
         snd_cnt  <= '0;
         iss_addr <= '0;
         iss_seg  <= '0;
         iss_act  <= 1'b0;
         inf_v    <= 1'b0;
         inf_m    <= 1'b0;
         q_cnt    <= '0;
         q[0]     <= '0;
         q[1]     <= '0;
         q[2]     <= '0;
         reject   <= 1'b0;
         bad_lvl  <= 1'b0;
         cycles   <= '0;
      end else begin
         bad_lvl <= state == IDLE && go && !legal;
         if (busy && cycles != '1) cycles <= cycles + CNT_W'(1);
         inf_v <= issue;
         inf_m <= issue && iss_seg == 3'd4;
         if (pop) begin
            q[0] <= q[1];
            q[1] <= q[2];
         end
         if (push) q[wi] <= din;
         q_cnt <= q_cnt + 2'(push) - 2'(pop);
         if (issue) begin
            iss_addr <= iss_last ? '0 : iss_addr + 14'd1;
            if (iss_last) begin
               iss_seg <= iss_seg == 3'd6 ? 3'd0 : iss_seg + 3'd1;
               iss_act <= iss_seg != 3'd6;
            end
         end
         if (pop) snd_cnt <= snd_last ? '0 : snd_cnt + 14'd1;
         if (state == IDLE) begin
            if (go && legal) begin
               state  <= START;
               st_cnt <= '0;
               lvl    <= lvl_i;
               mlen   <= mlen_i;
               cycles <= '0;
               reject <= 1'b0;
            end
         end else if (state == START) begin
            st_cnt <= st_cnt + 2'd1;
            if (st_cnt == 2'd2) begin
               state   <= RHO;
               iss_act <= 1'b1;
            end
         end else if (state == RESULT) begin
            if (res_valid) begin
               state  <= IDLE;
               reject <= res_data == 64'd1;
            end
         end else if (in_seg && pop && snd_last) begin
            state <= state + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_verify_load_sequencer.sv
// tb_verify_load_sequencer: directed runs with random data, random backpressure and a stream reference model.
module tb_verify_load_sequencer;
   logic        clk = 1'b0, rst = 1'b0, go = 1'b0, core_ready = 1'b1, res_valid = 1'b0;
   logic [2:0]  lvl_i = '0;
   logic [15:0] mlen_i = '0;
   logic [63:0] rd_data = '0, res_data = '0;
   logic        busy, done, reject, bad_lvl, rd_en, core_start, core_valid, res_ready;
   logic [31:0] cycles;
   logic [2:0]  rd_seg, core_lvl;
   logic [9:0]  rd_addr;
   logic [1:0]  core_mode;
   logic [63:0] core_data;
   int          n_cmp = 0, n_err = 0, cyc = 0;
   int          start_n = 0, start_cyc = 0, done_n = 0, bad_n = 0;
   int          cur_lvl = 2, cur_ml = 0;
   logic        rnd_ready = 1'b0, pv = 1'b0, pr = 1'b1;
   logic [63:0] pd = '0;
   logic [31:0] salt = '0;
   logic [63:0] obs [$];
   int          obs_cyc [$];
   int          rd_cyc [$];

   verify_load_sequencer #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .go(go), .lvl_i(lvl_i), .mlen_i(mlen_i),
      .busy(busy), .done(done), .reject(reject), .bad_lvl(bad_lvl), .cycles(cycles),
      .rd_en(rd_en), .rd_seg(rd_seg), .rd_addr(rd_addr), .rd_data(rd_data),
      .core_start(core_start), .core_mode(core_mode), .core_lvl(core_lvl),
      .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stream order: 0 rho, 1 c, 2 z, 3 t1, 4 mlen, 5 m, 6 h.
   function automatic int seglen(input int l, input int s, input int ml);
      int li;
      int zt [3];
      int tt [3];
      int ht [3];
      zt = '{288, 400, 560};
      tt = '{160, 240, 320};
      ht = '{11, 8, 11};
      li = (l == 2) ? 0 : (l == 3) ? 1 : 2;
      if (s < 2) return 4;
      if (s == 2) return zt[li];
      if (s == 3) return tt[li];
      if (s == 4) return 1;
      if (s == 5) return (ml == 0) ? 1 : (ml + 7) / 8;
      return ht[li];
   endfunction

   function automatic logic [63:0] word(input logic [2:0] rs, input logic [9:0] a);
      return {salt, 13'd0, rs, 6'd0, a};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rd_en) rd_data <= word(rd_seg, rd_addr);

   initial forever begin
      @(posedge clk);
      #1 core_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (rst) begin
         if (pv && !pr) begin
            chk("hold_valid", core_valid, 1);
            chk("hold_data", core_data, pd);
         end
         if (core_valid && core_ready) begin
            obs.push_back(core_data);
            obs_cyc.push_back(cyc);
         end
         if (rd_en) begin
            rd_cyc.push_back(cyc);
            chk("rd_addr_range", rd_addr < seglen(cur_lvl, (rd_seg < 4) ? int'(rd_seg) : int'(rd_seg) + 1, cur_ml), 1);
         end
         if (core_start) begin
            start_n++;
            start_cyc = cyc;
         end
         if (done) done_n++;
         if (bad_lvl) bad_n++;
      end
      pv = core_valid && rst;
      pr = core_ready;
      pd = core_data;
   end

   task automatic run(input int l, input int ml, input logic rnd, input logic [63:0] rdat, input int d, input logic extra);
      logic [63:0] exp_q [$];
      int b0, r0, s0, d0, g, n, nbad, i, dc, first_bad;
      cur_lvl = l;
      cur_ml = ml;
      salt = $urandom;
      rnd_ready = rnd;
      for (int s = 0; s < 7; s++)
         for (int a = 0; a < seglen(l, s, ml); a++)
            exp_q.push_back((s == 4) ? 64'(ml) : word(3'((s < 4) ? s : s - 1), 10'(a)));
      n = exp_q.size();
      b0 = obs.size();
      r0 = rd_cyc.size();
      s0 = start_n;
      d0 = done_n;
      @(negedge clk);
      lvl_i = 3'(l);
      mlen_i = 16'(ml);
      go = 1'b1;
      g = cyc;
      @(negedge clk);
      go = 1'b0;
      chk("busy_after_go", busy, 1);
      chk("core_lvl", core_lvl, 64'(l));
      chk("core_mode", core_mode, 1);
      i = 0;
      while (!res_ready && i < 20000) begin
         if (extra && i == 50) begin
            lvl_i = 3'd3;
            go = 1'b1;
         end else go = 1'b0;
         @(negedge clk);
         i++;
      end
      go = 1'b0;
      chk("result_reached", i < 20000, 1);
      repeat (d) @(negedge clk);
      res_data = rdat;
      res_valid = 1'b1;
      #1;
      dc = cyc;
      chk("done_pulse", done, 1);
      @(negedge clk);
      res_valid = 1'b0;
      chk("done_low", done, 0);
      chk("busy_low", busy, 0);
      chk("reject", reject, rdat == 64'd1);
      chk("cycles_vs_done", cycles, 64'(dc - g));
      chk("done_count", done_n - d0, 1);
      chk("start_count", start_n - s0, 1);
      chk("start_cycle", start_cyc - g, 3);
      chk("beat_count", obs.size() - b0, 64'(n));
      chk("read_count", rd_cyc.size() - r0, 64'(n - 1));
      nbad = 0;
      first_bad = -1;
      for (int k = 0; k < n && b0 + k < obs.size(); k++)
         if (obs[b0 + k] !== exp_q[k]) begin
            nbad++;
            if (first_bad < 0) first_bad = k;
         end
      chk("stream_words", nbad, 0);
      if (first_bad >= 0) chk("first_bad_word", obs[b0 + first_bad], exp_q[first_bad]);
      if (!rnd && obs.size() - b0 == n && rd_cyc.size() > r0) begin
         chk("cycles_formula", cycles, 64'(6 + n + d));
         chk("startup", obs_cyc[b0] - rd_cyc[r0], 2);
         chk("no_gaps", obs_cyc[b0 + n - 1] - obs_cyc[b0], 64'(n - 1));
      end
   endtask

   initial begin
      int r0, b0, d0, i;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_reject", reject, 0);
      chk("rst_bad_lvl", bad_lvl, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_mode", core_mode, 1);
      chk("rst_core_lvl", core_lvl, 0);
      chk("rst_core_valid", core_valid, 0);
      chk("rst_core_data", core_data, 0);
      chk("rst_res_ready", res_ready, 0);
      @(negedge clk);
      rst = 1'b1;
      run(2, 33, 1'b0, 64'd0, 0, 1'b0);
      run(3, 0, 1'b0, 64'd1, 3, 1'b0);
      run(5, $urandom_range(1, 300), 1'b1, 64'd1, 2, 1'b0);
      r0 = rd_cyc.size();
      b0 = bad_n;
      @(negedge clk);
      lvl_i = 3'd4;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk("bad_lvl_pulse", bad_lvl, 1);
      chk("bad_busy", busy, 0);
      @(negedge clk);
      chk("bad_lvl_low", bad_lvl, 0);
      repeat (10) @(negedge clk);
      chk("bad_busy_later", busy, 0);
      chk("bad_no_rd", rd_cyc.size() - r0, 0);
      chk("bad_count", bad_n - b0, 1);
      cur_lvl = 2;
      cur_ml = 8;
      rnd_ready = 1'b0;
      d0 = done_n;
      @(negedge clk);
      lvl_i = 3'd2;
      mlen_i = 16'd8;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      i = 0;
      while (!(rd_en && rd_seg == 3'd2) && i < 1000) begin
         @(negedge clk);
         i++;
      end
      chk("reach_z", i < 1000, 1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_valid", core_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rd_en", rd_en, 0);
      chk("abort_res_ready", res_ready, 0);
      chk("abort_core_lvl", core_lvl, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk("abort_no_done", done_n - d0, 0);
      run(2, 8, 1'b0, 64'd0, 0, 1'b0);
      run(2, 17, 1'b0, 64'd2, 20, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1, "watchdog");
   end
endmodule
